// File: rtl/reg_arb_pkg.sv
// Shared types and sizes for the register-file write-port arbiter.
package reg_arb_pkg;

    typedef enum logic {INIT, RUN} arb_state_t;

    localparam int unsigned NUM_REGS   = 8;
    localparam int unsigned REG_SEL_W  = 3;
    // Counts 0..NUM_REGS so the cycle after the last sweep write is distinguishable
    localparam int unsigned INIT_CNT_W = $clog2(NUM_REGS) + 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, with wrap-around.
module rr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]                                  req,
    input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]    ptr,
    output logic [NUM_REQ-1:0]                                  grant,
    output logic [REG_SEL_W-1:0]                                grant_idx,
    output logic                                                any_grant
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((32'(ptr) + 32'(k)) % NUM_REQ);
            if (!any_grant && req[cand]) begin
                any_grant   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = REG_SEL_W'(cand);
            end
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Owns the 8x16 register-file write port: init sweep after reset, then round-robin
// arbitration among NUM_REQ writers. Define REQ0_PRIORITY_EN to give requester 0 absolute priority.
module reg_wr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned          NUM_REQ    = 3,
    parameter int unsigned          DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [REG_SEL_W*NUM_REQ-1:0]    req_dr,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            ld_reg,
    output logic [REG_SEL_W-1:0]            dr,
    output logic [DATA_WIDTH-1:0]           data_in,
    output logic [REG_SEL_W-1:0]            grant_id,
    output logic                            busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t              state_q, state_d;
    logic [INIT_CNT_W-1:0]   init_cnt_q, init_cnt_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic                    ld_reg_q, ld_reg_d;
    logic [REG_SEL_W-1:0]    dr_q, dr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [REG_SEL_W-1:0]    grant_id_q, grant_id_d;
    logic                    busy_q, busy_d;

    logic [NUM_REQ-1:0]      rr_req;
    logic [NUM_REQ-1:0]      rr_gnt;
    logic [REG_SEL_W-1:0]    rr_idx;
    logic                    rr_any;

    logic [NUM_REQ-1:0]      win_gnt;
    logic [REG_SEL_W-1:0]    win_idx;
    logic                    win_any;
    logic                    win_moves_ptr;
    logic [REG_SEL_W-1:0]    win_dr;
    logic [DATA_WIDTH-1:0]   win_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req       (rr_req),
        .ptr       (ptr_q),
        .grant     (rr_gnt),
        .grant_idx (rr_idx),
        .any_grant (rr_any)
    );

    // Winner selection, optionally overriding the ring with requester 0
    always_comb begin
`ifdef REQ0_PRIORITY_EN
        rr_req        = {req_valid[NUM_REQ-1:1], 1'b0};
        win_any       = req_valid[0] | rr_any;
        win_moves_ptr = !req_valid[0];
        if (req_valid[0]) begin
            win_gnt = {{(NUM_REQ-1){1'b0}}, 1'b1};
            win_idx = '0;
        end else begin
            win_gnt = rr_gnt;
            win_idx = rr_idx;
        end
`else
        rr_req        = req_valid;
        win_gnt       = rr_gnt;
        win_idx       = rr_idx;
        win_any       = rr_any;
        win_moves_ptr = 1'b1;
`endif
    end

    // Payload of the winning requester
    always_comb begin
        win_dr   = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_gnt[i]) begin
                win_dr   = req_dr[REG_SEL_W*i +: REG_SEL_W];
                win_data = req_data[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    assign req_ready = (state_q == RUN) ? win_gnt : '0;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ptr_d      = ptr_q;
        ld_reg_d   = 1'b0;
        dr_d       = dr_q;
        data_d     = data_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;

        case (state_q)
            INIT: begin
                // Leave once the r7 write is on the port
                if (init_cnt_q == INIT_CNT_W'(NUM_REGS)) begin
                    state_d = RUN;
                    busy_d  = 1'b0;
                end else begin
                    ld_reg_d   = 1'b1;
                    dr_d       = REG_SEL_W'(init_cnt_q);
                    data_d     = INIT_VALUE;
                    init_cnt_d = init_cnt_q + INIT_CNT_W'(1);
                end
            end
            RUN: begin
                if (win_any) begin
                    ld_reg_d   = 1'b1;
                    dr_d       = win_dr;
                    data_d     = win_data;
                    grant_id_d = win_idx;
                    if (win_moves_ptr) begin
                        if (win_idx == REG_SEL_W'(NUM_REQ - 1)) begin
                            ptr_d = '0;
                        end else begin
                            ptr_d = PTR_W'(win_idx + REG_SEL_W'(1));
                        end
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            ptr_q      <= '0;
            ld_reg_q   <= 1'b0;
            dr_q       <= '0;
            data_q     <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ptr_q      <= ptr_d;
            ld_reg_q   <= ld_reg_d;
            dr_q       <= dr_d;
            data_q     <= data_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

    assign ld_reg   = ld_reg_q;
    assign dr       = dr_q;
    assign data_in  = data_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule
